// File: rtl/fft_frame_ctrl_if.sv
// Signal bundle between fft_frame_ctrl and its surroundings: sample source,
// FFT core data/config channels, core output monitor and status.
interface fft_frame_ctrl_if #(
  parameter int unsigned CFG_W = 16
);
  logic [CFG_W-1:0] i_cfg_word;
  logic             i_cfg_load;
  logic [31:0]      i_data;
  logic             i_data_valid;
  logic             o_data_ready;
  logic [31:0]      o_fft_tdata;
  logic             o_fft_tvalid;
  logic             o_fft_tlast;
  logic             i_fft_tready;
  logic [CFG_W-1:0] o_cfg_tdata;
  logic             o_cfg_tvalid;
  logic             i_cfg_tready;
  logic             i_out_tvalid;
  logic             i_out_tready;
  logic             i_evt_tlast_err;
  logic             o_busy;
  logic [1:0]       o_err;
  logic [15:0]      o_frames_done;

  modport slave (
    input  i_cfg_word, i_cfg_load, i_data, i_data_valid, i_fft_tready,
           i_cfg_tready, i_out_tvalid, i_out_tready, i_evt_tlast_err,
    output o_data_ready, o_fft_tdata, o_fft_tvalid, o_fft_tlast,
           o_cfg_tdata, o_cfg_tvalid, o_busy, o_err, o_frames_done
  );

  modport master (
    output i_cfg_word, i_cfg_load, i_data, i_data_valid, i_fft_tready,
           i_cfg_tready, i_out_tvalid, i_out_tready, i_evt_tlast_err,
    input  o_data_ready, o_fft_tdata, o_fft_tvalid, o_fft_tlast,
           o_cfg_tdata, o_cfg_tvalid, o_busy, o_err, o_frames_done
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// FFT core sequencer: config write, framed sample gating with tlast, in-flight
// frame tracking and drained reconfiguration. Watchdog: FFT_FRAME_WATCHDOG_EN.
module fft_frame_ctrl #(
  parameter int unsigned      FRAME_LEN   = 1024,
  parameter int unsigned      CFG_W       = 16,
  parameter logic [CFG_W-1:0] CFG_DEFAULT = CFG_W'(16'h0001),
  parameter int unsigned      MAX_OUTST   = 4,
  parameter int unsigned      TIMEOUT_CYC = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fft_frame_ctrl_if.slave  bus
);

  localparam int unsigned     CW        = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned     OW        = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0]   LAST_IDX  = CW'(FRAME_LEN - 1);
  localparam logic [OW-1:0]   OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_CFG,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CFG_W-1:0] r_cfg_reg;
  logic [CFG_W-1:0] r_cfg_latch;
  logic             r_pending;
  logic             r_cfg_tvalid;
  logic             r_busy;
  logic             r_err0;
  logic             w_err1;
  logic [CW-1:0]    r_in_cnt;
  logic [CW-1:0]    r_out_cnt;
  logic [CW-1:0]    w_in_cnt_nxt;
  logic [CW-1:0]    w_out_cnt_nxt;
  logic [OW-1:0]    r_outst;
  logic [OW-1:0]    w_outst_nxt;
  logic [15:0]      r_frames_done;
  logic             w_gate;
  logic             w_apply;
  logic             w_fft_tvalid;
  logic             w_in_beat;
  logic             w_in_last;
  logic             w_out_beat;
  logic             w_out_ok;
  logic             w_out_wrap;
  logic             w_busy_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_gate      = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      ST_CFG: begin
        if (r_cfg_tvalid && bus.i_cfg_tready) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // A pending config blocks only the start of a new frame, never mid-frame.
        w_gate = ((r_outst < OUTST_MAX) || (r_in_cnt != '0)) &&
                 !(r_pending && (r_in_cnt == '0));
        if (r_pending && (r_in_cnt == '0)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_outst == '0) && (r_out_cnt == '0)) begin
          w_apply     = 1'b1;
          w_state_nxt = ST_CFG;
        end
      end
      default: w_state_nxt = ST_CFG;
    endcase
  end

  assign w_fft_tvalid = bus.i_data_valid & w_gate;
  assign w_in_beat    = w_fft_tvalid & bus.i_fft_tready;
  assign w_in_last    = w_in_beat & (r_in_cnt == LAST_IDX);
  assign w_out_beat   = bus.i_out_tvalid & bus.i_out_tready;
  assign w_out_ok     = w_out_beat & (r_outst != '0);
  assign w_out_wrap   = w_out_ok & (r_out_cnt == LAST_IDX);

  always_comb begin
    w_in_cnt_nxt  = w_in_beat ? r_in_cnt + CW'(1) : r_in_cnt;
    w_out_cnt_nxt = w_out_ok ? r_out_cnt + CW'(1) : r_out_cnt;
    w_outst_nxt   = r_outst;
    case ({w_in_last, w_out_wrap})
      2'b10:   w_outst_nxt = r_outst + OW'(1);
      2'b01:   w_outst_nxt = r_outst - OW'(1);
      default: w_outst_nxt = r_outst;
    endcase
    w_busy_nxt = (w_state_nxt != ST_RUN) || (w_outst_nxt != '0) ||
                 (w_in_cnt_nxt != '0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_CFG;
      r_cfg_reg     <= CFG_DEFAULT;
      r_cfg_latch   <= CFG_DEFAULT;
      r_pending     <= 1'b0;
      r_cfg_tvalid  <= 1'b0;
      r_busy        <= 1'b1;
      r_err0        <= 1'b0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_outst       <= '0;
      r_frames_done <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cfg_tvalid <= (w_state_nxt == ST_CFG);
      r_busy       <= w_busy_nxt;
      r_in_cnt     <= w_in_cnt_nxt;
      r_out_cnt    <= w_out_cnt_nxt;
      r_outst      <= w_outst_nxt;
      // A load landing on the drain-exit cycle is taken directly as the new config.
      if (w_apply) begin
        r_cfg_reg <= bus.i_cfg_load ? bus.i_cfg_word : r_cfg_latch;
      end
      if (bus.i_cfg_load) begin
        r_cfg_latch <= bus.i_cfg_word;
        r_pending   <= ~w_apply;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      if (bus.i_evt_tlast_err || (w_out_beat && (r_outst == '0))) begin
        r_err0 <= 1'b1;
      end
      if (w_out_wrap) r_frames_done <= r_frames_done + 16'd1;
    end
  end

`ifdef FFT_FRAME_WATCHDOG_EN
  localparam logic [12:0] WD_LIMIT = 13'(TIMEOUT_CYC);

  logic [12:0] r_wd_cnt;
  logic [12:0] w_wd_nxt;
  logic        r_wd_err;

  always_comb begin
    w_wd_nxt = '0;
    if ((r_state == ST_RUN) && ((r_in_cnt != '0) || (r_outst != '0)) &&
        !(w_in_beat || w_out_beat)) begin
      w_wd_nxt = (r_wd_cnt >= WD_LIMIT) ? r_wd_cnt : r_wd_cnt + 13'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wd_cnt <= '0;
      r_wd_err <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_nxt >= WD_LIMIT) r_wd_err <= 1'b1;
    end
  end

  assign w_err1 = r_wd_err;
`else
  assign w_err1 = 1'b0;
`endif

  assign bus.o_fft_tdata   = bus.i_data;
  assign bus.o_fft_tvalid  = w_fft_tvalid;
  assign bus.o_fft_tlast   = w_fft_tvalid & (r_in_cnt == LAST_IDX);
  assign bus.o_data_ready  = bus.i_fft_tready & w_gate;
  assign bus.o_cfg_tdata   = r_cfg_reg;
  assign bus.o_cfg_tvalid  = r_cfg_tvalid;
  assign bus.o_busy        = r_busy;
  assign bus.o_err         = {w_err1, r_err0};
  assign bus.o_frames_done = r_frames_done;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: frame-count reference model compared
// every cycle, plus directed scenario checks with literal expectations.
module tb_fft_frame_ctrl;

  localparam int FL  = 8;
  localparam int MXO = 2;
  localparam int TO  = 16;
`ifdef FFT_FRAME_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  fft_frame_ctrl_if #(.CFG_W(16)) bus ();

  fft_frame_ctrl #(
    .FRAME_LEN  (FL),
    .CFG_W      (16),
    .CFG_DEFAULT(16'h0001),
    .MAX_OUTST  (MXO),
    .TIMEOUT_CYC(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: progress kept as total sample/output-beat counts.
  typedef enum int {P_CFG, P_RUN, P_DRAIN} phase_t;
  phase_t      m_phase;
  int          m_acc;
  int          m_outb;
  bit          m_pending;
  logic [15:0] m_latch;
  logic [15:0] m_word;
  bit          m_cfgv;
  bit          m_err0;
  bit          m_err1;
  int          m_wd;
  int          m_peak;

  // Observations of DUT activity used by the directed checks.
  int          dut_acc;
  int          n_cfg_hs;
  logic [15:0] last_cfg;
  int          tl_q[$];

  always @(negedge clk) begin
    int    fly, in_pos, out_pos;
    bit    gate, e_tv, e_rdy, e_tl, e_busy, in_b, out_b, apply;
    phase_t nph;
    if (rst) begin
      m_phase = P_CFG; m_acc = 0; m_outb = 0; m_pending = 0;
      m_latch = 16'h0001; m_word = 16'h0001; m_cfgv = 0;
      m_err0 = 0; m_err1 = 0; m_wd = 0;
      chk("rst_cfg_tvalid", bus.o_cfg_tvalid, 1'b0);
      chk("rst_data_ready", bus.o_data_ready, 1'b0);
      chk("rst_fft_tvalid", bus.o_fft_tvalid, 1'b0);
      chk("rst_fft_tlast", bus.o_fft_tlast, 1'b0);
      chk("rst_busy", bus.o_busy, 1'b1);
      chk("rst_err", bus.o_err, 2'b00);
      chk("rst_frames_done", bus.o_frames_done, 16'h0000);
      chk("rst_cfg_tdata", bus.o_cfg_tdata, 16'h0001);
    end else begin
      fly     = m_acc / FL - m_outb / FL;
      in_pos  = m_acc % FL;
      out_pos = m_outb % FL;
      gate    = (m_phase == P_RUN) && (fly < MXO || in_pos != 0) &&
                !(m_pending && in_pos == 0);
      e_tv    = gate && bus.i_data_valid;
      e_rdy   = gate && bus.i_fft_tready;
      e_tl    = e_tv && (in_pos == FL - 1);
      e_busy  = (m_phase != P_RUN) || (fly != 0) || (in_pos != 0);

      chk("cfg_tvalid", bus.o_cfg_tvalid, m_cfgv);
      chk("cfg_tdata", bus.o_cfg_tdata, m_word);
      chk("fft_tvalid", bus.o_fft_tvalid, e_tv);
      chk("data_ready", bus.o_data_ready, e_rdy);
      chk("fft_tlast", bus.o_fft_tlast, e_tl);
      if (e_tv) chk("fft_tdata", bus.o_fft_tdata, bus.i_data);
      chk("busy", bus.o_busy, e_busy);
      chk("err", bus.o_err, {m_err1, m_err0});
      chk("frames_done", bus.o_frames_done, 16'((m_outb / FL) % 65536));

      if (bus.o_fft_tvalid && bus.i_fft_tready) begin
        if (bus.o_fft_tlast) tl_q.push_back(dut_acc);
        dut_acc++;
      end
      if (bus.o_cfg_tvalid && bus.i_cfg_tready) begin
        n_cfg_hs++;
        last_cfg = bus.o_cfg_tdata;
      end

      in_b  = e_tv && bus.i_fft_tready;
      out_b = bus.i_out_tvalid && bus.i_out_tready;
      if (WD_ON) begin
        if (m_phase == P_RUN && (in_pos != 0 || fly != 0) && !in_b && !out_b)
          m_wd = (m_wd >= TO) ? m_wd : m_wd + 1;
        else
          m_wd = 0;
        if (m_wd >= TO) m_err1 = 1;
      end
      nph = m_phase;
      apply = 0;
      case (m_phase)
        P_CFG:   if (m_cfgv && bus.i_cfg_tready) nph = P_RUN;
        P_RUN:   if (m_pending && in_pos == 0) nph = P_DRAIN;
        default: if (fly == 0 && out_pos == 0) begin nph = P_CFG; apply = 1; end
      endcase
      if (apply) m_word = bus.i_cfg_load ? bus.i_cfg_word : m_latch;
      if (bus.i_cfg_load) begin
        m_latch = bus.i_cfg_word;
        m_pending = !apply;
      end else if (apply) begin
        m_pending = 0;
      end
      if (out_b) begin
        if (fly == 0) m_err0 = 1;
        else m_outb++;
      end
      if (in_b) m_acc++;
      if (bus.i_evt_tlast_err) m_err0 = 1;
      m_phase = nph;
      m_cfgv  = (nph == P_CFG);
      fly = m_acc / FL - m_outb / FL;
      if (fly > m_peak) m_peak = fly;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      if (!bus.o_busy) break;
    end
    chk("idle_reached", bus.o_busy, 1'b0);
  endtask

  task automatic feed(input int n, input bit rnd);
    int base;
    base = dut_acc;
    for (int k = 0; k < 400 && dut_acc - base < n; k++) begin
      bus.i_data       = $urandom;
      bus.i_data_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.i_fft_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc();
    end
    bus.i_data_valid = 1'b0;
    bus.i_fft_tready = 1'b1;
    chk("feed_count", dut_acc - base, n);
  endtask

  task automatic emit_out(input int n);
    int sent;
    sent = 0;
    for (int k = 0; k < 400 && sent < n; k++) begin
      bus.i_out_tvalid = $urandom_range(0, 3) != 0;
      bus.i_out_tready = $urandom_range(0, 3) != 0;
      if (bus.i_out_tvalid && bus.i_out_tready) sent++;
      cyc();
    end
    bus.i_out_tvalid = 1'b0;
    bus.i_out_tready = 1'b0;
    chk("emit_count", sent, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    n_chk = 0; n_fail = 0; dut_acc = 0; n_cfg_hs = 0; last_cfg = '0; m_peak = 0;
    rst = 1'b1;
    bus.i_cfg_word = '0; bus.i_cfg_load = 1'b0; bus.i_data = '0;
    bus.i_data_valid = 1'b0; bus.i_fft_tready = 1'b1; bus.i_cfg_tready = 1'b1;
    bus.i_out_tvalid = 1'b0; bus.i_out_tready = 1'b0; bus.i_evt_tlast_err = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    wait_idle(20);
    chk("boot_cfg_handshakes", n_cfg_hs, 1);
    chk("boot_cfg_word", last_cfg, 16'h0001);

    // Two frames in, two frames out.
    tl_q.delete();
    m_peak = 0;
    feed(16, 1'b1);
    chk("tlast_count", tl_q.size(), 2);
    chk("tlast_first_idx", tl_q[0], 7);
    chk("tlast_second_idx", tl_q[1], 15);
    emit_out(16);
    cyc();
    chk("two_frames_done", bus.o_frames_done, 16'd2);
    chk("two_frames_idle", bus.o_busy, 1'b0);
    chk("model_peak_outst", m_peak, 2);

    // Outstanding limit stalls input until an output frame completes.
    base = dut_acc;
    bus.i_data_valid = 1'b1;
    repeat (40) begin bus.i_data = $urandom; cyc(); end
    chk("limit_accepted", dut_acc - base, 16);
    chk("limit_ready_low", bus.o_data_ready, 1'b0);
    bus.i_data_valid = 1'b0;
    emit_out(8);
    feed(8, 1'b0);
    chk("resume_accepted", dut_acc - base, 24);
    emit_out(16);
    cyc();
    chk("five_frames_done", bus.o_frames_done, 16'd5);

    // Mid-frame reconfiguration waits for tlast and a full drain.
    base = dut_acc;
    bus.i_data_valid = 1'b1;
    for (int k = 0; k < 50 && dut_acc - base < 3; k++) begin bus.i_data = $urandom; cyc(); end
    bus.i_cfg_word = 16'h0002; bus.i_cfg_load = 1'b1; bus.i_data = $urandom;
    cyc();
    bus.i_cfg_load = 1'b0;
    bus.i_cfg_tready = 1'b0;
    repeat (20) begin bus.i_data = $urandom; cyc(); end
    chk("reconfig_frame_completes", dut_acc - base, 8);
    chk("drain_ready_low", bus.o_data_ready, 1'b0);
    emit_out(8);
    repeat (3) cyc();
    chk("cfg_pending_valid", bus.o_cfg_tvalid, 1'b1);
    chk("cfg_pending_word", bus.o_cfg_tdata, 16'h0002);
    chk("no_accept_drain_cfg", dut_acc - base, 8);
    bus.i_data_valid = 1'b0;
    bus.i_cfg_tready = 1'b1;
    wait_idle(20);
    chk("reconfig_handshakes", n_cfg_hs, 2);
    chk("reconfig_word", last_cfg, 16'h0002);

    // Core tlast event, then an output beat with nothing in flight.
    bus.i_evt_tlast_err = 1'b1;
    cyc();
    bus.i_evt_tlast_err = 1'b0;
    chk("evt_err_set", bus.o_err[0], 1'b1);
    bus.i_out_tvalid = 1'b1; bus.i_out_tready = 1'b1;
    cyc();
    bus.i_out_tvalid = 1'b0; bus.i_out_tready = 1'b0;
    cyc();
    chk("err0_sticky", bus.o_err[0], 1'b1);
    chk("underflow_frames", bus.o_frames_done, 16'd6);
    chk("underflow_idle", bus.o_busy, 1'b0);

    // Randomised traffic, including sporadic reconfiguration.
    repeat (600) begin
      bus.i_data       = $urandom;
      bus.i_data_valid = $urandom_range(0, 3) != 0;
      bus.i_fft_tready = $urandom_range(0, 3) != 0;
      bus.i_out_tvalid = $urandom_range(0, 1);
      bus.i_out_tready = $urandom_range(0, 3) != 0;
      bus.i_cfg_tready = $urandom_range(0, 1);
      bus.i_cfg_load   = $urandom_range(0, 63) == 0;
      bus.i_cfg_word   = 16'($urandom);
      cyc();
    end
    bus.i_data_valid = 1'b0; bus.i_out_tvalid = 1'b0; bus.i_out_tready = 1'b0;
    bus.i_cfg_load = 1'b0; bus.i_cfg_tready = 1'b1; bus.i_fft_tready = 1'b1;

    // Watchdog on a stalled frame, then reset mid-frame.
    rst = 1'b1;
    n_cfg_hs = 0;
    repeat (2) cyc();
    rst = 1'b0;
    wait_idle(20);
    feed(3, 1'b0);
    repeat (16) cyc();
    chk("watchdog_flag", bus.o_err[1], WD_ON);
    chk("watchdog_busy", bus.o_busy, 1'b1);
    rst = 1'b1;
    n_cfg_hs = 0;
    cyc();
    chk("midrst_err", bus.o_err, 2'b00);
    chk("midrst_frames", bus.o_frames_done, 16'd0);
    chk("midrst_busy", bus.o_busy, 1'b1);
    chk("midrst_cfg_tvalid", bus.o_cfg_tvalid, 1'b0);
    rst = 1'b0;
    wait_idle(20);
    chk("midrst_cfg_handshakes", n_cfg_hs, 1);
    chk("midrst_cfg_word", last_cfg, 16'h0001);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Sequencer in front of the FFT core in the FFT peripheral.
- After reset it writes the core configuration channel. It then gates the 32-bit sample stream into the core and generates tlast every FRAME_LEN accepted samples.
- It tracks frames in flight by observing the core output handshake.
- Runtime reconfiguration (e.g. forward/inverse, scaling) is applied only at a frame boundary, after the core has fully drained.

Parameters:
- FRAME_LEN, 1024, samples per FFT frame; must be a power of 2, minimum 2.
- CFG_W, 16, width of the core config word.
- CFG_DEFAULT, 16'h0001, config word sent after reset.
- MAX_OUTST, 4, frames allowed in flight; input stalls when this is reached.
- TIMEOUT_CYC, 4096, watchdog limit in cycles (optional feature only).

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_cfg_word, in, CFG_W, new config word; sampled when i_cfg_load=1.
- i_cfg_load, in, 1, one-cycle reconfiguration request.
- i_data, in, 32, sample {im[31:16], re[15:0]}.
- i_data_valid, in, 1, sample valid.
- o_data_ready, out, 1, sample accepted when high together with i_data_valid.
- o_fft_tdata, out, 32, to core s_axis_data_tdata.
- o_fft_tvalid, out, 1, to core s_axis_data_tvalid.
- o_fft_tlast, out, 1, to core s_axis_data_tlast.
- i_fft_tready, in, 1, from core s_axis_data_tready.
- o_cfg_tdata, out, CFG_W, to core s_axis_config_tdata.
- o_cfg_tvalid, out, 1, to core s_axis_config_tvalid.
- i_cfg_tready, in, 1, from core s_axis_config_tready.
- i_out_tvalid, in, 1, core m_axis_data_tvalid (monitor only).
- i_out_tready, in, 1, core m_axis_data_tready (monitor only).
- i_evt_tlast_err, in, 1, OR of core event_tlast_unexpected and event_tlast_missing.
- o_busy, out, 1, high while not in RUN or while frames are in flight.
- o_err, out, 2, sticky: bit0 core tlast event, bit1 watchdog; cleared only by reset.
- o_frames_done, out, 16, count of completed output frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async, i_rst=1):
  - State CFG, cfg_reg=CFG_DEFAULT.
  - Counters in_cnt, out_cnt, outst, o_frames_done all 0.
  - o_err=0, pending=0.
  - o_cfg_tvalid=0, o_data_ready=0, o_fft_tvalid=0, o_fft_tlast=0, o_busy=1.
  - First cycle after release: o_cfg_tvalid=1.
- States:
  - CFG: o_cfg_tvalid=1, o_cfg_tdata=cfg_reg. On i_cfg_tready, go to RUN next cycle. o_cfg_tvalid drops the same edge.
  - RUN: combinational pass-through.
    - o_fft_tvalid = i_data_valid & gate.
    - o_data_ready = i_fft_tready & gate.
    - gate = (outst<MAX_OUTST | in_cnt!=0) & !(pending & in_cnt==0).
    - o_fft_tdata = i_data.
    - o_fft_tlast = (in_cnt==FRAME_LEN-1) while o_fft_tvalid=1.
  - DRAIN: entered from RUN when pending=1 and in_cnt==0. gate=0. When outst==0 and out_cnt==0, load cfg_reg from the latched word, clear pending, and go to CFG.
- Input beat = o_fft_tvalid & i_fft_tready.
  - in_cnt increments per beat and wraps to 0 after FRAME_LEN-1.
  - A beat with tlast increments outst.
- Output beat = i_out_tvalid & i_out_tready.
  - out_cnt increments per beat and wraps at FRAME_LEN-1.
  - On wrap: outst decrements and o_frames_done increments.
- Same-cycle outst increment and decrement leave outst unchanged.
- Output beat with outst==0: ignored (no underflow), and o_err[0] is set.
- i_cfg_load in any state:
  - Latch i_cfg_word and set pending.
  - A second load before it is applied overwrites the latched word; last write wins.
  - A load in DRAIN updates the word already in flight toward CFG.
  - A load in CFG is applied after the current config transfer, via RUN then DRAIN.
- A mid-frame load never truncates the frame: the switch happens after the tlast beat.
- o_busy = (state!=RUN) | (outst!=0) | (in_cnt!=0).
- i_evt_tlast_err=1 sets o_err[0].
- All outputs registered except the RUN pass-through signals (o_fft_tdata, o_fft_tvalid, o_fft_tlast, o_data_ready).

Optional Feature:
- Macro: FFT_FRAME_WATCHDOG_EN.
- With the macro defined:
  - A 13-bit counter counts idle cycles in RUN while in_cnt!=0 or outst!=0.
  - It resets on any input or output beat.
  - On reaching TIMEOUT_CYC it sets o_err[1]; the counter saturates.
  - Behaviour is otherwise unchanged; there is no auto-recovery.
- Without the macro: no counter logic; o_err[1] is tied 0.

Test Plan:
- Reset, i_cfg_tready=1 -> o_cfg_tvalid high one cycle with o_cfg_tdata=0x0001, then RUN; o_busy=0.
- FRAME_LEN=8; stream 16 samples, core always ready; echo 16 output beats -> o_fft_tlast on beats 7 and 15, outst peaks at 2, o_frames_done=2, o_busy=0.
- MAX_OUTST=2 with no output beats; offer 24 samples -> exactly 16 accepted, o_data_ready=0 afterward. Release 8 output beats -> input resumes.
- i_cfg_load with 0x0002 at in_cnt=3 -> frame completes to tlast; DRAIN until outputs are echoed; CFG sends 0x0002; no samples accepted during DRAIN or CFG.
- Assert i_evt_tlast_err one cycle; then issue an output beat with outst=0 -> o_err=2'b01 stays set, outst stays 0, o_frames_done unchanged.
- With FFT_FRAME_WATCHDOG_EN and TIMEOUT_CYC=16: feed 3 samples, then idle 16 cycles -> o_err[1]=1. Assert i_rst mid-frame -> all counters and o_err cleared; CFG is repeated with 0x0001.
